// File: rtl/muldiv_seq.sv
// Sequences one MULT/MULTU/DIV/DIVU op through the shared iterative units and
// produces a single-cycle HI/LO write-back pulse. Includes a divide-by-zero fast path and a watchdog.
module muldiv_seq #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [1:0]  op_sel,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        ex_hold,
   output logic        mul_start,
   output logic        mul_signed,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic        mul_ready,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_annul,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        stallreq,
   output logic        hi_we,
   output logic        lo_we,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata,
   output logic        busy,
   output logic        err
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StMulRun,
      StDivRun,
      StDone,
      StHold,
      StErr
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      op_sel_q, op_sel_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         op_sel_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_sel_q <= op_sel_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_sel_d  = op_sel_q;
      a_d       = a_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mul_start = 1'b0;
      div_start = 1'b0;
      div_annul = 1'b0;
      stallreq  = 1'b0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      err       = 1'b0;

      unique case (state_q)
         StIdle: begin
            stallreq = op_valid & ~flush;
            if (op_valid && !flush) begin
               op_sel_d = op_sel;
               a_d      = src_a;
               b_d      = src_b;
               cnt_d    = '0;
               if (!op_sel[1]) begin
                  state_d = StMulRun;
               end else if (src_b != 32'd0) begin
                  state_d = StDivRun;
               end else begin
                  // Divide-by-zero never reaches the divider.
                  hi_d    = src_a;
                  lo_d    = 32'hFFFF_FFFF;
                  state_d = StDone;
               end
            end
         end
         StMulRun: begin
            stallreq  = 1'b1;
            mul_start = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (mul_ready) begin
               hi_d    = mul_result[63:32];
               lo_d    = mul_result[31:0];
               state_d = StDone;
            end else if (cnt_q == CntLast) begin
               state_d = StErr;
            end
         end
         StDivRun: begin
            stallreq  = 1'b1;
            div_start = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (div_ready) begin
               hi_d    = div_result[63:32];
               lo_d    = div_result[31:0];
               state_d = StDone;
            end else if (cnt_q == CntLast) begin
               div_annul = 1'b1;
               state_d   = StErr;
            end
         end
         StDone: begin
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            state_d = ex_hold ? StHold : StIdle;
         end
         StHold: begin
            if (!ex_hold) begin
               state_d = StIdle;
            end
         end
         StErr: begin
            err     = 1'b1;
            state_d = ex_hold ? StHold : StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Flush overrides everything, including a result arriving this same cycle.
      if (flush) begin
         state_d  = StIdle;
         hi_d     = hi_q;
         lo_d     = lo_q;
         hi_we    = 1'b0;
         lo_we    = 1'b0;
         stallreq = 1'b0;
         if (state_q == StDivRun) begin
            div_annul = 1'b1;
         end
      end
   end

   assign busy       = (state_q != StIdle);
   assign mul_signed = busy & ~op_sel_q[1] & ~op_sel_q[0];
   assign div_signed = busy & op_sel_q[1] & ~op_sel_q[0];
   assign mul_a      = a_q;
   assign mul_b      = b_q;
   assign div_a      = a_q;
   assign div_b      = b_q;
   assign hi_wdata   = hi_q;
   assign lo_wdata   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized checks of muldiv_seq. The bench plays both arithmetic units and predicts
// the HI/LO write-back from plain signed/unsigned arithmetic on the issued operands.
module tb_muldiv_seq;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        op_valid = 1'b0;
   logic [1:0]  op_sel = '0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        flush = 1'b0;
   logic        ex_hold = 1'b0;
   logic        mul_start, mul_signed;
   logic [31:0] mul_a, mul_b;
   logic        mul_ready = 1'b0;
   logic [63:0] mul_result = '0;
   logic        div_start, div_signed;
   logic [31:0] div_a, div_b;
   logic        div_annul;
   logic        div_ready = 1'b0;
   logic [63:0] div_result = '0;
   logic        stallreq, hi_we, lo_we;
   logic [31:0] hi_wdata, lo_wdata;
   logic        busy, err;

   int n_assert = 0;
   int n_fail   = 0;

   muldiv_seq #(.TIMEOUT_CYC(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .op_valid   (op_valid),
      .op_sel     (op_sel),
      .src_a      (src_a),
      .src_b      (src_b),
      .flush      (flush),
      .ex_hold    (ex_hold),
      .mul_start  (mul_start),
      .mul_signed (mul_signed),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_ready  (mul_ready),
      .mul_result (mul_result),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_annul  (div_annul),
      .div_ready  (div_ready),
      .div_result (div_result),
      .stallreq   (stallreq),
      .hi_we      (hi_we),
      .lo_we      (lo_we),
      .hi_wdata   (hi_wdata),
      .lo_wdata   (lo_wdata),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
      longint sa, sb;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
      longint sa, sb, q, r;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [63:0] ref_result(input logic [1:0] sel, input logic [31:0] a,
                                              input logic [31:0] b);
      if (!sel[1]) return mul_model(a, b, ~sel[0]);
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      return div_model(a, b, ~sel[0]);
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1(tag, |{mul_start, mul_signed, mul_a, mul_b, div_start, div_signed, div_a, div_b,
                  div_annul, stallreq, hi_we, lo_we, hi_wdata, lo_wdata, busy, err}, 1'b0);
   endtask

   // Issues one op, plays the unit with the given latency and checks the full sequence.
   task automatic run_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input int lat, output logic [31:0] got_hi, output logic [31:0] got_lo);
      logic [63:0] exp;
      logic        is_div, zero;
      exp    = ref_result(sel, a, b);
      is_div = sel[1];
      zero   = is_div && (b == 32'd0);
      op_valid = 1'b1;
      op_sel   = sel;
      src_a    = a;
      src_b    = b;
      settle();
      chk1("issue_stallreq", stallreq, 1'b1);
      chk1("issue_busy", busy, 1'b0);
      chk1("issue_starts", mul_start | div_start, 1'b0);
      tick();
      if (!zero) begin
         for (int c = 0; c <= lat; c++) begin
            if (c == lat) begin
               if (is_div) begin
                  div_ready  = 1'b1;
                  div_result = div_model(div_a, div_b, div_signed);
               end else begin
                  mul_ready  = 1'b1;
                  mul_result = mul_model(mul_a, mul_b, mul_signed);
               end
            end
            settle();
            chk1("run_mul_start", mul_start, !is_div);
            chk1("run_div_start", div_start, is_div);
            chk1("run_stallreq", stallreq, 1'b1);
            chk1("run_no_write", hi_we | lo_we, 1'b0);
            chk1("run_signed", is_div ? div_signed : mul_signed, ~sel[0]);
            if (c == 0) begin
               chk32("run_opa", is_div ? div_a : mul_a, a);
               chk32("run_opb", is_div ? div_b : mul_b, b);
            end
            tick();
            mul_ready = 1'b0;
            div_ready = 1'b0;
         end
      end
      op_valid = 1'b0;
      settle();
      chk1("done_hi_we", hi_we, 1'b1);
      chk1("done_lo_we", lo_we, 1'b1);
      chk32("done_hi", hi_wdata, exp[63:32]);
      chk32("done_lo", lo_wdata, exp[31:0]);
      chk1("done_stallreq", stallreq, 1'b0);
      chk1("done_starts", mul_start | div_start, 1'b0);
      got_hi = hi_wdata;
      got_lo = lo_wdata;
      tick();
      chk1("after_busy", busy, 1'b0);
      chk1("after_no_write", hi_we | lo_we, 1'b0);
   endtask

   initial begin
      logic [31:0] gh, gl;
      logic [1:0]  rs;
      logic [31:0] ra, rb;

      // Reset
      tick();
      tick();
      settle();
      chk_all_zero("reset_outputs");
      rst = 1'b1;
      tick();

      // MULT -3 * 5, ready 4 cycles after start
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 4, gh, gl);
      chk32("mult_hi", gh, 32'hFFFF_FFFF);
      chk32("mult_lo", gl, 32'hFFFF_FFF1);

      // DIVU 7/2 and DIV -7/2
      run_op(2'b11, 32'd7, 32'd2, 2, gh, gl);
      chk32("divu_hi", gh, 32'd1);
      chk32("divu_lo", gl, 32'd3);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 3, gh, gl);
      chk32("div_hi", gh, 32'hFFFF_FFFF);
      chk32("div_lo", gl, 32'hFFFF_FFFD);

      // Divide by zero fast path
      run_op(2'b10, 32'h1234_5678, 32'd0, 0, gh, gl);
      chk32("div0_hi", gh, 32'h1234_5678);
      chk32("div0_lo", gl, 32'hFFFF_FFFF);

      // Flush three cycles into DIV_RUN, with div_ready in the same cycle
      op_valid = 1'b1;
      op_sel   = 2'b10;
      src_a    = 32'd100;
      src_b    = 32'd7;
      tick();
      for (int c = 0; c < 3; c++) begin
         settle();
         chk1("flush_pre_div_start", div_start, 1'b1);
         chk1("flush_pre_annul", div_annul, 1'b0);
         tick();
      end
      flush      = 1'b1;
      div_ready  = 1'b1;
      div_result = div_model(div_a, div_b, div_signed);
      settle();
      chk1("flush_annul", div_annul, 1'b1);
      chk1("flush_stallreq", stallreq, 1'b0);
      chk1("flush_no_write", hi_we | lo_we, 1'b0);
      tick();
      flush     = 1'b0;
      div_ready = 1'b0;
      op_valid  = 1'b0;
      settle();
      chk1("flush_idle", busy, 1'b0);
      chk1("flush_annul_once", div_annul, 1'b0);
      chk1("flush_no_write_after", hi_we | lo_we, 1'b0);
      tick();
      chk1("flush_no_late_write", hi_we | lo_we, 1'b0);

      // ex_hold across DONE with op_valid still high
      op_valid = 1'b1;
      op_sel   = 2'b01;
      src_a    = 32'd6;
      src_b    = 32'd7;
      tick();
      mul_ready  = 1'b1;
      mul_result = mul_model(mul_a, mul_b, mul_signed);
      tick();
      mul_ready = 1'b0;
      ex_hold   = 1'b1;
      settle();
      chk1("hold_done_we", hi_we, 1'b1);
      chk32("hold_done_lo", lo_wdata, 32'd42);
      for (int h = 0; h < 3; h++) begin
         tick();
         chk1("hold_no_write", hi_we | lo_we, 1'b0);
         chk1("hold_no_start", mul_start, 1'b0);
         chk1("hold_stallreq", stallreq, 1'b0);
         chk1("hold_busy", busy, 1'b1);
      end
      ex_hold = 1'b0;
      settle();
      chk1("hold_release_busy", busy, 1'b1);
      tick();
      chk1("reissue_stallreq", stallreq, 1'b1);
      chk1("reissue_idle", busy, 1'b0);
      tick();
      chk1("reissue_start", mul_start, 1'b1);
      mul_ready  = 1'b1;
      mul_result = mul_model(mul_a, mul_b, mul_signed);
      tick();
      mul_ready = 1'b0;
      op_valid  = 1'b0;
      settle();
      chk1("reissue_write", hi_we, 1'b1);
      chk32("reissue_lo", lo_wdata, 32'd42);
      tick();

      // Watchdog on both units
      for (int u = 0; u < 2; u++) begin
         op_valid = 1'b1;
         op_sel   = (u == 0) ? 2'b00 : 2'b10;
         src_a    = 32'd9;
         src_b    = 32'd4;
         tick();
         for (int c = 0; c < int'(TO); c++) begin
            settle();
            chk1("wd_start", (u == 0) ? mul_start : div_start, 1'b1);
            chk1("wd_no_err", err, 1'b0);
            chk1("wd_stallreq", stallreq, 1'b1);
            chk1("wd_annul", div_annul, (u == 1) && (c == int'(TO) - 1));
            tick();
         end
         op_valid = 1'b0;
         settle();
         chk1("wd_err", err, 1'b1);
         chk1("wd_no_write", hi_we | lo_we, 1'b0);
         chk1("wd_stall_drop", stallreq, 1'b0);
         chk1("wd_starts_off", mul_start | div_start, 1'b0);
         tick();
         chk1("wd_err_pulse", err, 1'b0);
         chk1("wd_idle", busy, 1'b0);
      end

      // Reset mid-RUN
      op_valid = 1'b1;
      op_sel   = 2'b11;
      src_a    = 32'd50;
      src_b    = 32'd3;
      tick();
      tick();
      chk1("midrst_running", div_start, 1'b1);
      rst      = 1'b0;
      op_valid = 1'b0;
      tick();
      chk_all_zero("midrst_outputs");
      rst = 1'b1;
      tick();

      // Randomized ops
      for (int i = 0; i < 40; i++) begin
         rs = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
              ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         run_op(rs, ra, rb, int'($urandom_range(0, 6)), gh, gl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer in the EX stage for the shared iterative multiplier and divider units.
- Accepts one MULT/MULTU/DIV/DIVU op at a time, drives each unit's start/ready handshake, and holds the pipeline stall request until the op completes.
- Produces a single-cycle HI/LO write-back pulse.
- Handles flush/annul, the divide-by-zero fast path, and a completion watchdog.

Parameters:
TIMEOUT_CYC, 64, max cycles in a RUN state waiting for ready before abort (must be ≥ 2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
op_valid  in  1  EX holds a mul/div instruction
op_sel  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  32  rs operand
src_b  in  32  rt operand
flush  in  1  kill in-flight op
ex_hold  in  1  downstream stall holding EX register
mul_start  out  1  level start to multiplier
mul_signed  out  1  signed multiply
mul_a, mul_b  out  32 each  multiplier operands
mul_ready  in  1  multiplier result valid
mul_result  in  64  {hi,lo}
div_start  out  1  level start to divider
div_signed  out  1  signed divide
div_a, div_b  out  32 each  dividend, divisor
div_annul  out  1  cancel divider
div_ready  in  1  divider result valid
div_result  in  64  {remainder,quotient}
stallreq  out  1  stall request to the stall controller
hi_we, lo_we  out  1 each  HI/LO write enables
hi_wdata, lo_wdata  out  32 each  write data
busy  out  1  state != IDLE
err  out  1  one-cycle pulse on watchdog abort

Behaviour:
Reset (rst=0 at an edge):
- State goes to IDLE; counter and latched operands/result clear.
- All outputs are 0.
- Any in-flight unit op is abandoned. No annul is issued; the units are reset by the same rst.

States: IDLE, MUL_RUN, DIV_RUN, DONE, HOLD, ERR.

IDLE:
- stallreq = op_valid & ~flush, combinational (same cycle as issue).
- On op_valid & ~flush:
  - Latch op_sel, src_a and src_b.
  - op_sel[1]=0 → MUL_RUN.
  - op_sel[1]=1 and src_b≠0 → DIV_RUN.
  - op_sel[1]=1 and src_b=0 → DONE, with latched hi=src_a and lo=32'hFFFFFFFF.

MUL_RUN / DIV_RUN:
- Unit start = 1 with the latched operands. signed = ~op_sel[0].
- stallreq = 1.
- The cycle counter clears on entry and increments each cycle.
- On ready=1: latch the unit's 64-bit result (hi=[63:32], lo=[31:0]) → DONE.
- Else, when the counter reaches TIMEOUT_CYC-1 → ERR, with div_annul=1 in that cycle if in DIV_RUN.

DONE:
- hi_we = lo_we = 1 with the latched data, for exactly one cycle. stallreq = 0. Starts = 0.
- Next state: ex_hold=1 → HOLD, else → IDLE.
- The op is never re-accepted in DONE.

HOLD:
- No writes. stallreq = 0.
- Stay while ex_hold=1; → IDLE when ex_hold=0.
- Prevents re-issuing the same instruction still sitting in EX.

ERR:
- err = 1, no writes, stallreq = 0.
- Next state follows the same ex_hold rule as DONE.

flush=1 (any state except reset):
- Next state is IDLE.
- No writes in that cycle; hi_we and lo_we are forced to 0, even in DONE.
- div_annul = 1 in that cycle if the state is DIV_RUN.
- stallreq = 0 in that cycle.
- Flush and ready arriving in the same cycle: flush wins and the result is discarded.

Latency: issue at cycle N → RUN from N+1 → ready seen at cycle M → DONE at M+1.
- Divide-by-zero: DONE at N+1.

Only one unit start is ever asserted at a time; both are 0 outside the RUN states.

Test Plan:
- MULT src_a=32'hFFFFFFFD (−3), src_b=5, multiplier ready 4 cycles after start:
  - stallreq high from the issue cycle through the ready cycle.
  - DONE pulse: hi_wdata=32'hFFFFFFFF, lo_wdata=32'hFFFFFFF1, mul_signed=1.
- DIVU 7/2: div_signed=0; writes hi=1, lo=3. DIV −7/2 (32'hFFFFFFF9, 2): div_signed=1; writes hi=32'hFFFFFFFF, lo=32'hFFFFFFFD.
- DIV src_a=32'h12345678, src_b=0:
  - div_start never asserted.
  - DONE on the next cycle: hi=32'h12345678, lo=32'hFFFFFFFF.
- Flush during DIV_RUN (3 cycles in):
  - div_annul=1 for one cycle and IDLE next.
  - No hi_we/lo_we, even if div_ready=1 in the flush cycle.
- ex_hold=1 across DONE with op_valid held for 3 more cycles:
  - Exactly one write pulse and no second mul_start.
  - A new op is accepted only after ex_hold falls.
- TIMEOUT_CYC=8, mul_ready held 0:
  - err pulses after 8 RUN cycles, with no writes.
  - stallreq drops.
  - rst=0 asserted mid-RUN on a separate run forces all outputs to 0 on the next edge.
